imem_access_arbiter: RTL and testbench

- Sits in front of the single-port synchronous instruction memory and shares it between two requesters: core instruction fetch and the program loader (boot/debug writes and readback).
- After reset it runs in BOOT mode, where only the loader can access memory.
- On a loader completion pulse it switches to RUN mode: fetch has priority, and a starvation counter guarantees the loader eventually gets access.
- Validates addresses and sequences one memory access per cycle.

---
 rtl/imem_access_arbiter.sv | 122 ++++++++++++
 tb/tb_imem_access_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_access_arbiter.sv
// Arbiter sharing a single-port synchronous instruction memory between core fetch and the loader.
// BOOT mode serves only the loader; RUN mode prefers fetch with a starvation guard for the loader.
module imem_access_arbiter #(
  parameter int unsigned MEM_DEPTH    = 64,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned IDX_W       = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req_valid,
  output logic             fetch_req_ready,
  input  logic [31:0]      fetch_addr,
  output logic             fetch_rsp_valid,
  output logic [31:0]      fetch_rsp_data,
  output logic             fetch_rsp_err,
  input  logic             load_req_valid,
  output logic             load_req_ready,
  input  logic             load_we,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_wdata,
  input  logic             load_done,
  output logic             load_rsp_valid,
  output logic [31:0]      load_rsp_data,
  output logic             load_rsp_err,
  output logic             run_mode,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [31:0] ADDR_END = 32'(4 * MEM_DEPTH);
  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e     state_q;
  logic [3:0] starve_q, starve_d;
  logic       fetch_pend_q, fetch_err_q;
  logic       load_pend_q, load_err_q, load_rd_q;

  logic fetch_err, load_err;
  logic fetch_gnt, load_gnt;
  logic starved;

  assign fetch_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= ADDR_END);
  assign load_err  = (load_addr[1:0] != 2'b00) || (load_addr >= ADDR_END);
  assign starved   = (starve_q == LIMIT);

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (state_q == StBoot) begin
      load_gnt = load_req_valid;
    end else if (load_req_valid && (starved || !fetch_req_valid)) begin
      load_gnt = 1'b1;
    end else begin
      fetch_gnt = fetch_req_valid;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_gnt && !load_err) begin
      mem_en    = 1'b1;
      mem_we    = load_we;
      mem_addr  = load_addr[IDX_W+1:2];
      mem_wdata = load_we ? load_wdata : 32'h0;
    end else if (fetch_gnt && !fetch_err) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr[IDX_W+1:2];
    end
  end

  // Count only RUN-mode cycles where the loader waits and loses; any grant or idle clears it.
  always_comb begin
    starve_d = 4'd0;
    if (state_q == StRun && load_req_valid && !load_gnt) begin
      starve_d = starved ? starve_q : 4'(starve_q + 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StBoot;
      starve_q     <= 4'd0;
      fetch_pend_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      load_pend_q  <= 1'b0;
      load_err_q   <= 1'b0;
      load_rd_q    <= 1'b0;
    end else begin
      case (state_q)
        StBoot:  if (load_done) state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StBoot;
      endcase
      starve_q     <= starve_d;
      fetch_pend_q <= fetch_gnt;
      fetch_err_q  <= fetch_gnt && fetch_err;
      load_pend_q  <= load_gnt;
      load_err_q   <= load_gnt && load_err;
      load_rd_q    <= load_gnt && !load_err && !load_we;
    end
  end

  assign run_mode        = (state_q == StRun);
  assign fetch_req_ready = fetch_gnt;
  assign load_req_ready  = load_gnt;

  assign fetch_rsp_valid = fetch_pend_q;
  assign fetch_rsp_err   = fetch_err_q;
  assign fetch_rsp_data  = (fetch_pend_q && !fetch_err_q) ? mem_rdata : 32'h0;
  assign load_rsp_valid  = load_pend_q;
  assign load_rsp_err    = load_err_q;
  assign load_rsp_data   = load_rd_q ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter: vector table plus reset-mid-transaction sequence.
module tb_imem_access_arbiter;

  localparam logic [31:0] W0 = 32'h00C0006B;
  localparam logic [31:0] W1 = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_valid, fetch_req_ready;
  logic [31:0] fetch_addr;
  logic        fetch_rsp_valid, fetch_rsp_err;
  logic [31:0] fetch_rsp_data;
  logic        load_req_valid, load_req_ready, load_we, load_done;
  logic [31:0] load_addr, load_wdata;
  logic        load_rsp_valid, load_rsp_err;
  logic [31:0] load_rsp_data;
  logic        run_mode, mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_access_arbiter #(.MEM_DEPTH(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr), .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_data(fetch_rsp_data), .fetch_rsp_err(fetch_rsp_err),
    .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
    .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_done(load_done), .load_rsp_valid(load_rsp_valid),
    .load_rsp_data(load_rsp_data), .load_rsp_err(load_rsp_err),
    .run_mode(run_mode), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory model.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic        fv;
    logic [31:0] fa;
    logic        lv;
    logic        lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic        ld;
    logic        fr;
    logic        lr;
    logic        men;
    logic        mwe;
    logic [5:0]  maddr;
    logic        frv;
    logic [31:0] frd;
    logic        fre;
    logic        lrv;
    logic [31:0] lrd;
    logic        lre;
    logic        run;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fa, input logic lv, input logic lwe,
                       input logic [31:0] la, input logic [31:0] lwd, input logic ld);
    fetch_req_valid = fv;
    fetch_addr      = fa;
    load_req_valid  = lv;
    load_we         = lwe;
    load_addr       = la;
    load_wdata      = lwd;
    load_done       = ld;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Both responders must never pulse together.
  always @(negedge clk) begin
    if (fetch_rsp_valid && load_rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_exclusive: got both valid expected at most one at %0t", $time);
    end
  end

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.fv, v.fa, v.lv, v.lwe, v.la, v.lwd, v.ld);
    #2;
    check({tag, ".fetch_ready"}, 32'(fetch_req_ready), 32'(v.fr));
    check({tag, ".load_ready"}, 32'(load_req_ready), 32'(v.lr));
    check({tag, ".mem_en"}, 32'(mem_en), 32'(v.men));
    check({tag, ".mem_we"}, 32'(mem_we), 32'(v.mwe));
    check({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.maddr));
    @(posedge clk);
    #1;
    check({tag, ".fetch_rsp_valid"}, 32'(fetch_rsp_valid), 32'(v.frv));
    check({tag, ".fetch_rsp_data"}, fetch_rsp_data, v.frd);
    check({tag, ".fetch_rsp_err"}, 32'(fetch_rsp_err), 32'(v.fre));
    check({tag, ".load_rsp_valid"}, 32'(load_rsp_valid), 32'(v.lrv));
    check({tag, ".load_rsp_data"}, load_rsp_data, v.lrd);
    check({tag, ".load_rsp_err"}, 32'(load_rsp_err), 32'(v.lre));
    check({tag, ".run_mode"}, 32'(run_mode), 32'(v.run));
  endtask

  // Hand sequence helper: drive both requesters and check which one wins.
  task automatic contend(input string name, input logic exp_fr);
    @(negedge clk);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    #2;
    check({name, ".fetch_ready"}, 32'(fetch_req_ready), 32'(exp_fr));
    check({name, ".load_ready"}, 32'(load_req_ready), 32'(!exp_fr));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset.run_mode", 32'(run_mode), 32'd0);
    check("reset.fetch_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
    check("reset.load_rsp_valid", 32'(load_rsp_valid), 32'd0);
    check("reset.rsp_data", fetch_rsp_data | load_rsp_data, 32'd0);
    check("reset.readies", 32'({fetch_req_ready, load_req_ready}), 32'd0);

    //    fv   fa        lv   lwe  la     lwd ld   fr   lr   men  mwe  maddr frv  frd  fre  lrv  lrd  lre  run
    v = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,
          1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs.push_back(v);
    vecs.push_back(v);
    v = '{1'b1, 32'h4,   1'b1, 1'b1, 32'h4, W0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd1,
          1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs.push_back(v);
    v = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1,
          1'b0, 32'h0, 1'b0, 1'b1, W0,    1'b0, 1'b0};
    vecs.push_back(v);
    v = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h6, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,
          1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0};
    vecs.push_back(v);
    v = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8, W1,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd2,
          1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1};
    vecs.push_back(v);
    v = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2,
          1'b1, W1,    1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs.push_back(v);
    v = '{1'b1, 32'h6,   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,
          1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs.push_back(v);
    v = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,
          1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs.push_back(v);
    v = '{1'b1, 32'hFC,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd63,
          1'b1, 32'hA500003F, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs.push_back(v);
    v = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,
          1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs.push_back(v);
    v = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1,
          1'b0, 32'h0, 1'b0, 1'b1, W0,    1'b0, 1'b1};
    vecs.push_back(v);
    // Starvation: two rounds of four fetch grants followed by one forced loader grant.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        v = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4,
              1'b1, 32'hA5000004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs.push_back(v);
      end
      v = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2,
            1'b0, 32'h0, 1'b0, 1'b1, W1, 1'b0, 1'b1};
      vecs.push_back(v);
    end

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset in the cycle after a fetch acceptance, with the starve counter part-way up.
    contend("pre_rst0", 1'b1);
    contend("pre_rst1", 1'b1);
    contend("pre_rst2", 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.fetch_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
    check("rst_mid.run_mode", 32'(run_mode), 32'd0);
    @(negedge clk);
    idle();
    fetch_req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      check("post_rst.fetch_ready", 32'(fetch_req_ready), 32'd0);
      check("post_rst.fetch_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
      check("post_rst.run_mode", 32'(run_mode), 32'd0);
      @(negedge clk);
    end
    idle();
    load_done = 1'b1;
    @(negedge clk);
    idle();
    #2;
    check("post_rst.run_again", 32'(run_mode), 32'd1);
    for (int k = 0; k < 4; k++) contend($sformatf("post_rst_starve%0d", k), 1'b1);
    contend("post_rst_starve4", 1'b0);
    @(negedge clk);
    idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
